// File: rtl/oam_dma_ctrl.sv
// Sprite OAM DMA sequencer: halts the 6502 via RDY, then copies XFER_LEN bytes
// from CPU page $PP00 to the PPU OAM data port over the shared bus.
// Optional feature macro: OAM_DMA_ALIGN_EN (adds the ALIGN cycle and the
// cycle-parity flag used to choose it).
module oam_dma_ctrl #(
    parameter logic [15:0] TRIG_ADDR = 16'h4014,
    parameter logic [15:0] OAM_PORT  = 16'h2004,
    parameter int unsigned XFER_LEN  = 256
) (
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_rw,
    input  logic [7:0]  data_bus_in,
    output logic        cpu_rdy,
    output logic        bus_grant,
    output logic [15:0] dma_addr,
    output logic        dma_rw,
    output logic [7:0]  dma_data_out,
    output logic        busy
);

    localparam int unsigned CNT_W = 9;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XFER_LEN);

`ifdef OAM_DMA_ALIGN_EN
    typedef enum logic [2:0] {
        IDLE, HALT_WAIT, DUMMY, ALIGN, READ, WRITE
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, HALT_WAIT, DUMMY, READ, WRITE
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [7:0]       page_q, page_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cpu_rdy_q, cpu_rdy_d;
    logic             bus_grant_q, bus_grant_d;
    logic [15:0]      dma_addr_q, dma_addr_d;
    logic             dma_rw_q, dma_rw_d;
    logic [7:0]       dma_data_out_q, dma_data_out_d;
    logic             busy_q, busy_d;
`ifdef OAM_DMA_ALIGN_EN
    logic             cyc_odd_q, cyc_odd_d;
`endif

    // Next-state, counter and data latch; outputs are derived from the next
    // state so that every output is a flop.
    always_comb begin
        state_d        = state_q;
        page_d         = page_q;
        cnt_d          = cnt_q;
        dma_data_out_d = dma_data_out_q;
`ifdef OAM_DMA_ALIGN_EN
        cyc_odd_d      = ~cyc_odd_q;
`endif
        case (state_q)
            IDLE: begin
                // Detection looks only at cpu_* so the DMA's own bus cycles never retrigger.
                if (!cpu_rw && cpu_addr == TRIG_ADDR) begin
                    page_d  = cpu_data_out;
                    cnt_d   = '0;
                    state_d = HALT_WAIT;
                end
            end
            HALT_WAIT: begin
                // RDY only takes effect on a CPU read cycle.
                if (cpu_rw) begin
                    state_d = DUMMY;
                end
            end
            DUMMY: begin
`ifdef OAM_DMA_ALIGN_EN
                state_d = cyc_odd_q ? ALIGN : READ;
`else
                state_d = READ;
`endif
            end
`ifdef OAM_DMA_ALIGN_EN
            ALIGN: begin
                state_d = READ;
            end
`endif
            READ: begin
                dma_data_out_d = data_bus_in;
                state_d        = WRITE;
            end
            WRITE: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = (cnt_d == LAST_CNT) ? IDLE : READ;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cpu_rdy_d   = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        bus_grant_d = (state_d == READ) || (state_d == WRITE);
        dma_rw_d    = (state_d != WRITE);
        if (state_d == READ) begin
            // Low byte wraps within the page; bit 8 of the counter is never used here.
            dma_addr_d = {page_d, cnt_d[7:0]};
        end else if (state_d == WRITE) begin
            dma_addr_d = OAM_PORT;
        end else begin
            dma_addr_d = '0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_ph1) begin
        if (rst) begin
            state_q        <= IDLE;
            page_q         <= '0;
            cnt_q          <= '0;
            cpu_rdy_q      <= 1'b1;
            bus_grant_q    <= 1'b0;
            dma_addr_q     <= '0;
            dma_rw_q       <= 1'b1;
            dma_data_out_q <= '0;
            busy_q         <= 1'b0;
`ifdef OAM_DMA_ALIGN_EN
            cyc_odd_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            page_q         <= page_d;
            cnt_q          <= cnt_d;
            cpu_rdy_q      <= cpu_rdy_d;
            bus_grant_q    <= bus_grant_d;
            dma_addr_q     <= dma_addr_d;
            dma_rw_q       <= dma_rw_d;
            dma_data_out_q <= dma_data_out_d;
            busy_q         <= busy_d;
`ifdef OAM_DMA_ALIGN_EN
            cyc_odd_q      <= cyc_odd_d;
`endif
        end
    end

    assign cpu_rdy      = cpu_rdy_q;
    assign bus_grant    = bus_grant_q;
    assign dma_addr     = dma_addr_q;
    assign dma_rw       = dma_rw_q;
    assign dma_data_out = dma_data_out_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: full 256-byte transfers, HALT_WAIT stall,
// mid-transfer reset, non-trigger accesses and a 1-byte instance.
module tb_oam_dma_ctrl;

    logic        clk_ph1;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_rw;
    logic [7:0]  data_bus_in;
    logic        cpu_rdy, bus_grant, dma_rw, busy;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data_out;

    logic [15:0] cpu1_addr;
    logic [7:0]  cpu1_data_out;
    logic        cpu1_rw;
    logic [7:0]  data1_in;
    logic        rdy1, grant1, rw1, busy1;
    logic [15:0] addr1;
    logic [7:0]  data1_out;

    int checks = 0;
    int errors = 0;
    bit par = 1'b0;

    oam_dma_ctrl u_dut (
        .clk_ph1(clk_ph1), .rst(rst), .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
        .cpu_rw(cpu_rw), .data_bus_in(data_bus_in), .cpu_rdy(cpu_rdy), .bus_grant(bus_grant),
        .dma_addr(dma_addr), .dma_rw(dma_rw), .dma_data_out(dma_data_out), .busy(busy)
    );

    oam_dma_ctrl #(.XFER_LEN(1)) u_dut1 (
        .clk_ph1(clk_ph1), .rst(rst), .cpu_addr(cpu1_addr), .cpu_data_out(cpu1_data_out),
        .cpu_rw(cpu1_rw), .data_bus_in(data1_in), .cpu_rdy(rdy1), .bus_grant(grant1),
        .dma_addr(addr1), .dma_rw(rw1), .dma_data_out(data1_out), .busy(busy1)
    );

    // Page $02 holds n^A5; other pages hold n^page^3C.
    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        if (a[15:8] == 8'h02) return a[7:0] ^ 8'hA5;
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    assign data_bus_in = (bus_grant && dma_rw) ? mem_rd(dma_addr) : 8'hFF;
    assign data1_in    = (grant1 && rw1) ? mem_rd(addr1) : 8'hFF;

    initial clk_ph1 = 1'b0;
    always #5 clk_ph1 = ~clk_ph1;

    // Advance one CPU cycle; par mirrors the parity flag after the edge.
    task automatic tick();
        @(posedge clk_ph1);
        if (rst) par = 1'b0;
        else     par = ~par;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_idle();
        cpu_rw = 1'b1; cpu_addr = 16'h8000; cpu_data_out = 8'h00;
    endtask

    // Trigger and follow one transfer; abort_at >= 0 resets during that byte's WRITE.
    task automatic do_xfer(input string tn, input logic [7:0] page, input int stall,
                           input bit want_odd, input int abort_at);
        int halted, t, idx, first_rd;
        bit done, aligned;
        // Parity seen at DUMMY = current parity flipped (stall+2) times.
        if ((par ^ bit'((stall + 2) % 2)) != want_odd) tick();
        cpu_rw = 1'b0; cpu_addr = 16'h4014; cpu_data_out = page;
        tick();
        chk({tn, " trig busy"}, 32'(busy), 32'd1);
        chk({tn, " trig rdy"}, 32'(cpu_rdy), 32'd0);
        for (int s = 0; s < stall; s++) begin
            // Stalled write tail, deliberately aimed at the trigger address.
            cpu_rw = 1'b0; cpu_addr = 16'h4014; cpu_data_out = 8'h55;
            tick();
            chk({tn, " stall rdy"}, 32'(cpu_rdy), 32'd0);
            chk({tn, " stall grant"}, 32'(bus_grant), 32'd0);
        end
        cpu_idle();
        tick();
        aligned = par;
`ifndef OAM_DMA_ALIGN_EN
        aligned = 1'b0;
`endif
        chk({tn, " dummy grant"}, 32'(bus_grant), 32'd0);
        chk({tn, " dummy rdy"}, 32'(cpu_rdy), 32'd0);
        halted = 1; t = 0; idx = 0; first_rd = -1; done = 1'b0;
        while (!done && t < 600) begin
            tick();
            t++;
            if (cpu_rdy) begin
                done = 1'b1;
            end else begin
                halted++;
                if (bus_grant && dma_rw) begin
                    if (first_rd < 0) first_rd = t;
                    chk({tn, " rd addr"}, 32'(dma_addr), 32'({page, 8'(idx)}));
                end else if (bus_grant && !dma_rw) begin
                    chk({tn, " wr addr"}, 32'(dma_addr), 32'h2004);
                    chk({tn, " wr data"}, 32'(dma_data_out), 32'(mem_rd({page, 8'(idx)})));
                    if (idx == abort_at) begin
                        rst = 1'b1;
                        tick();
                        rst = 1'b0;
                        chk({tn, " abort rdy"}, 32'(cpu_rdy), 32'd1);
                        chk({tn, " abort grant"}, 32'(bus_grant), 32'd0);
                        chk({tn, " abort busy"}, 32'(busy), 32'd0);
                        chk({tn, " abort rw"}, 32'(dma_rw), 32'd1);
                        return;
                    end
                    idx++;
                end
            end
        end
        chk({tn, " done in budget"}, 32'(done), 32'd1);
        chk({tn, " halted cycles"}, 32'(halted), aligned ? 32'd514 : 32'd513);
        chk({tn, " byte count"}, 32'(idx), 32'd256);
        chk({tn, " first read offset"}, 32'(first_rd), aligned ? 32'd2 : 32'd1);
        chk({tn, " end busy"}, 32'(busy), 32'd0);
        chk({tn, " end grant"}, 32'(bus_grant), 32'd0);
    endtask

    initial begin
        int rd1, wr1;
        bit ok1;
        rst = 1'b1;
        cpu_idle();
        cpu1_rw = 1'b1; cpu1_addr = 16'h8000; cpu1_data_out = 8'h00;
        tick();
        tick();
        rst = 1'b0;

        chk("reset rdy", 32'(cpu_rdy), 32'd1);
        chk("reset grant", 32'(bus_grant), 32'd0);
        chk("reset addr", 32'(dma_addr), 32'd0);
        chk("reset rw", 32'(dma_rw), 32'd1);
        chk("reset data", 32'(dma_data_out), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset rdy len1", 32'(rdy1), 32'd1);

        // Non-trigger accesses leave the block idle.
        cpu_rw = 1'b0; cpu_addr = 16'h4015; cpu_data_out = 8'h02; tick();
        chk("w4015 rdy", 32'(cpu_rdy), 32'd1);
        cpu_rw = 1'b0; cpu_addr = 16'h2004; cpu_data_out = 8'h02; tick();
        chk("w2004 rdy", 32'(cpu_rdy), 32'd1);
        cpu_rw = 1'b1; cpu_addr = 16'h4014; tick();
        chk("r4014 rdy", 32'(cpu_rdy), 32'd1);
        chk("r4014 busy", 32'(busy), 32'd0);
        cpu_idle(); tick();

        do_xfer("even", 8'h02, 0, 1'b0, -1);
        cpu_idle(); tick();
        do_xfer("odd", 8'h02, 0, 1'b1, -1);
        cpu_idle(); tick();
        do_xfer("stall", 8'h02, 2, 1'b0, -1);
        cpu_idle(); tick();
        do_xfer("abort", 8'h02, 0, 1'b0, 100);
        cpu_idle(); tick();
        chk("post abort idle rdy", 32'(cpu_rdy), 32'd1);
        do_xfer("page3", 8'h03, 0, 1'b0, -1);
        cpu_idle(); tick();

        // Reset wins over a coincident trigger.
        rst = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h4014; cpu_data_out = 8'h02;
        tick();
        rst = 1'b0; cpu_idle();
        tick();
        chk("rst+trig busy", 32'(busy), 32'd0);
        chk("rst+trig rdy", 32'(cpu_rdy), 32'd1);

        // One-byte instance.
        cpu1_rw = 1'b0; cpu1_addr = 16'h4014; cpu1_data_out = 8'h07;
        tick();
        chk("len1 trig rdy", 32'(rdy1), 32'd0);
        cpu1_rw = 1'b1; cpu1_addr = 16'h8000;
        rd1 = 0; wr1 = 0; ok1 = 1'b0;
        for (int c = 0; c < 12 && !ok1; c++) begin
            tick();
            if (grant1 && rw1) begin
                rd1++;
                chk("len1 rd addr", 32'(addr1), 32'h0700);
            end else if (grant1 && !rw1) begin
                wr1++;
                chk("len1 wr addr", 32'(addr1), 32'h2004);
                chk("len1 wr data", 32'(data1_out), 32'h3B);
            end
            if (rdy1) ok1 = 1'b1;
        end
        chk("len1 released", 32'(ok1), 32'd1);
        chk("len1 reads", 32'(rd1), 32'd1);
        chk("len1 writes", 32'(wr1), 32'd1);
        chk("len1 busy", 32'(busy1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Sprite DMA sequencer for the NES CPU bus. A CPU write to $4014 triggers it.
- It halts the 6502 through RDY, takes ownership of the shared Addr_bus/data bus, and copies XFER_LEN bytes from CPU page $PP00 to the PPU OAM data port.
- It sits between the CPU core and the system bus mux and owns the mux select. Bus control returns to the CPU when the copy finishes.

Parameters:
- TRIG_ADDR, 16'h4014, CPU write address that starts a DMA; the write data is the source page.
- OAM_PORT, 16'h2004, destination address driven on every DMA write cycle.
- XFER_LEN, 256, bytes per transfer; legal range 1..256.

Ports:
- clk_ph1  in  1  system clock; one CPU cycle per rising edge.
- rst  in  1  synchronous reset, active-high.
- cpu_addr  in  16  CPU address output.
- cpu_data_out  in  8  CPU write data.
- cpu_rw  in  1  CPU read/write; 1 = read.
- data_bus_in  in  8  shared read data bus.
- cpu_rdy  out  1  RDY to CPU; 0 = CPU halted.
- bus_grant  out  1  1 = bus mux selects the DMA address/rw/data.
- dma_addr  out  16  DMA address.
- dma_rw  out  1  DMA read/write; 1 = read.
- dma_data_out  out  8  DMA write data.
- busy  out  1  high from the cycle after the trigger until the transfer completes.

Behaviour:
- All outputs are registered. Reset values: cpu_rdy=1, bus_grant=0, dma_addr=0, dma_rw=1, dma_data_out=0, busy=0, state=IDLE, byte counter=0, cycle-parity flag=0.
- Cycle-parity flag cyc_odd: toggles every clk_ph1 edge; cleared only by rst.
- Trigger: in IDLE with cpu_rw=0 and cpu_addr==TRIG_ADDR at an edge. Latch page=cpu_data_out, clear the counter, go to HALT_WAIT, set busy=1 and cpu_rdy=0.
- HALT_WAIT: the 6502 honours RDY only on read cycles. Stay in HALT_WAIT while cpu_rw=0. When cpu_rw=1, go to DUMMY.
- DUMMY: one cycle, bus_grant=0; the CPU repeats its stalled read. Next state is ALIGN if cyc_odd=1 at this edge, otherwise READ.
- ALIGN: one cycle, bus_grant=0, then READ.
- READ: bus_grant=1, dma_rw=1, dma_addr={page, cnt[7:0]}. At the edge, latch data_bus_in into dma_data_out and go to WRITE.
- WRITE: bus_grant=1, dma_rw=0, dma_addr=OAM_PORT, dma_data_out holds the latched byte. At the edge, cnt increments.
  - If the new cnt == XFER_LEN: go to IDLE with cpu_rdy=1, bus_grant=0, busy=0 on the following cycle.
  - Otherwise go to READ.
- cnt is 9 bits so that XFER_LEN=256 terminates cleanly. The low 8 bits address within the page and never carry into the page byte.
- Halted length for XFER_LEN=256, counted from the first DUMMY cycle through the last WRITE: 513 cycles if not aligned, 514 if aligned.
- Triggers are ignored in every state except IDLE, including the DMA's own bus activity, because detection uses only cpu_* inputs.
- A trigger with page=$20..$3F is legal; PPU register side effects are system-level and not this block's concern.
- rst in any state: the next cycle shows reset values. The transfer is aborted, the CPU is released, and no partial-state resume occurs.
- A CPU write to TRIG_ADDR in the same cycle as rst: reset wins, no DMA.

Optional Feature:
- Macro OAM_DMA_ALIGN_EN.
- Defined: ALIGN state exists; the transfer takes 513 or 514 cycles depending on cyc_odd at DUMMY.
- Undefined: ALIGN state and cyc_odd are not built. DUMMY always goes straight to READ; the transfer is fixed at 513 cycles for XFER_LEN=256.

Test Plan:
- Memory $0200+n = n^8'hA5. Trigger write $02 to $4014, next cycle is a CPU read, cyc_odd=0 at DUMMY.
  - Required: cpu_rdy low for exactly 513 cycles from DUMMY.
  - Required: 256 DMA reads $0200..$02FF, each followed by a write to $2004 with data n^A5 in order.
  - Required: busy and bus_grant drop together with cpu_rdy rising.
- Same as above with cyc_odd=1 at DUMMY, OAM_DMA_ALIGN_EN defined -> 514 halted cycles; first DMA read occurs 2 cycles after DUMMY.
- Trigger followed by 2 further CPU write cycles (cpu_rw=0, modelling a stalled RMW tail) -> HALT_WAIT held 2 cycles; DUMMY starts on the first cpu_rw=1 cycle; byte stream unchanged.
- rst asserted during the WRITE of byte 100 -> next cycle: cpu_rdy=1, bus_grant=0, busy=0, dma_rw=1. A new trigger with page $03 then completes a full clean transfer starting at $0300.
- CPU writes to $4015 and $2004, and CPU reads of $4014 -> no state change; cpu_rdy stays 1.
- XFER_LEN=1 instance, trigger page $07 -> exactly one read of $0700 and one write to $2004, then release.
